// File: rtl/mdu_ctrl.sv
// mdu_ctrl: iterative RV32M multiply/divide unit controller.
//
// Multiplies use a 32-step shift-add on operand magnitudes, divides use a
// 32-step restoring divide on magnitudes; a FIX cycle then applies sign
// correction and half selection before a one-cycle DONE pulse.
//
// Build option:
//   MDU_DIV_EN  defined   -> DIV/DIVU/REM/REMU supported, including the
//                            divide-by-zero and signed-overflow fast paths.
//               undefined -> divider removed; funct3[2]=1 ops finish at once
//                            with result 0 and illegal=1 on the done pulse.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset
//   start     in   M-extension op issued (sampled only in IDLE)
//   funct3    in   op select (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   rs1_data  in   operand A / dividend
//   rs2_data  in   operand B / divisor
//   flush     in   abort the in-flight op
//   busy      out  stall request to the core
//   done      out  one-cycle completion pulse, result valid alongside
//   result    out  rd write data, held until the next completion
//   illegal   out  pulses with done when the op is unsupported

module mdu_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        illegal
);

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e      state_q;
    logic [5:0]  cnt_q;
    logic [2:0]  funct3_q;
    logic        a_neg_q;
    logic        b_neg_q;
    logic [31:0] opnd_q;    // multiplicand for MUL*, divisor magnitude for DIV*
    logic [63:0] acc_q;     // {hi, lo} for MUL*, {remainder, quotient} for DIV*
    logic [31:0] result_q;
    logic        done_q;
    logic        illegal_q;

    // Operand sign handling
    logic        sign_a;
    logic        sign_b;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] mag_a;
    logic [31:0] mag_b;

    always_comb begin
        sign_a = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
        sign_b = funct3[2] ? ~funct3[0] : ~funct3[1];
        a_neg  = sign_a & rs1_data[31];
        b_neg  = sign_b & rs2_data[31];
        mag_a  = a_neg ? (32'd0 - rs1_data) : rs1_data;
        mag_b  = b_neg ? (32'd0 - rs2_data) : rs2_data;
    end

    // Ops that complete straight from IDLE without iterating
    logic        fast_hit;
    logic        fast_illegal;
    logic [31:0] fast_result;

`ifdef MDU_DIV_EN
    logic div_by_zero;
    logic div_ovf;

    always_comb begin
        div_by_zero  = funct3[2] & (rs2_data == 32'd0);
        // Signed -2^31 / -1 overflows the magnitude divider
        div_ovf      = funct3[2] & ~funct3[0] & (rs1_data == 32'h8000_0000) &
                       (rs2_data == 32'hFFFF_FFFF);
        fast_hit     = div_by_zero | div_ovf;
        fast_illegal = 1'b0;
        if (div_by_zero) begin
            fast_result = funct3[1] ? rs1_data : 32'hFFFF_FFFF;
        end else begin
            fast_result = funct3[1] ? 32'd0 : 32'h8000_0000;
        end
    end
`else
    always_comb begin
        fast_hit     = funct3[2];
        fast_illegal = 1'b1;
        fast_result  = 32'd0;
    end
`endif

    // One radix-2 iteration
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [63:0] acc_next;

    always_comb begin
        mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
        mul_next = {mul_sum, acc_q[31:1]};
    end

`ifdef MDU_DIV_EN
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic [63:0] div_next;

    always_comb begin
        div_shift = {acc_q[63:32], acc_q[31]};
        div_diff  = div_shift - {1'b0, opnd_q};
        // No borrow means the shifted remainder covers the divisor
        if (!div_diff[32]) begin
            div_next = {div_diff[31:0], acc_q[30:0], 1'b1};
        end else begin
            div_next = {div_shift[31:0], acc_q[30:0], 1'b0};
        end
        acc_next = funct3_q[2] ? div_next : mul_next;
    end
`else
    always_comb begin
        acc_next = mul_next;
    end
`endif

    // Sign correction and half selection
    logic [63:0] prod_fixed;
    logic [31:0] fix_result;

    always_comb begin
        prod_fixed = (a_neg_q ^ b_neg_q) ? (64'd0 - acc_q) : acc_q;
        fix_result = (funct3_q == 3'b000) ? prod_fixed[31:0] : prod_fixed[63:32];
`ifdef MDU_DIV_EN
        if (funct3_q[2]) begin
            if (funct3_q[1]) begin
                // Remainder takes the dividend's sign
                fix_result = a_neg_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
            end else begin
                fix_result = (a_neg_q ^ b_neg_q) ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= 6'd0;
            funct3_q  <= 3'd0;
            a_neg_q   <= 1'b0;
            b_neg_q   <= 1'b0;
            opnd_q    <= 32'd0;
            acc_q     <= 64'd0;
            result_q  <= 32'd0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start && !flush) begin
                        funct3_q <= funct3;
                        a_neg_q  <= a_neg;
                        b_neg_q  <= b_neg;
                        if (fast_hit) begin
                            result_q  <= fast_result;
                            illegal_q <= fast_illegal;
                            done_q    <= 1'b1;
                            state_q   <= StDone;
                        end else begin
                            cnt_q   <= 6'd0;
                            opnd_q  <= funct3[2] ? mag_b : mag_a;
                            acc_q   <= {32'd0, funct3[2] ? mag_a : mag_b};
                            state_q <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    if (flush) begin
                        cnt_q   <= 6'd0;
                        state_q <= StIdle;
                    end else begin
                        acc_q <= acc_next;
                        if (cnt_q == 6'd31) begin
                            cnt_q   <= 6'd0;
                            state_q <= StFix;
                        end else begin
                            cnt_q <= cnt_q + 6'd1;
                        end
                    end
                end
                StFix: begin
                    if (flush) begin
                        state_q <= StIdle;
                    end else begin
                        result_q <= fix_result;
                        done_q   <= 1'b1;
                        state_q  <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // busy includes the accepting IDLE cycle so the core stalls immediately
    always_comb begin
        busy = ~rst & (((state_q == StIdle) & start & ~flush) |
                       (state_q == StCalc) | (state_q == StFix));
    end

    assign done    = done_q;
    assign result  = result_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed testbench for mdu_ctrl. Cycle 0 is the cycle in which start is
// presented in IDLE; cycle n is the cycle after the n-th following rising edge.
// Outputs are sampled on the falling edge.

module tb_mdu_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        illegal;

    int n_vec = 0;
    int n_bad = 0;

    int          lat;
    logic [31:0] res;
    logic        ill;
    int          berr;

    mdu_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .funct3   (funct3),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .flush    (flush),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .illegal  (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
        $fatal(1);
    end

    // Issue one op and wait (bounded) for done; measures latency, result,
    // illegal and the number of cycles where busy differed from 1..1,0.
    task automatic run_op(input bit sync, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, output int o_lat, output logic [31:0] o_res,
                          output logic o_ill, output int o_berr);
        if (sync) @(negedge clk);
        start    = 1'b1;
        funct3   = f;
        rs1_data = a;
        rs2_data = b;
        #1;
        o_berr = (busy !== 1'b1) ? 1 : 0;
        o_lat  = -1;
        o_res  = 'x;
        o_ill  = 1'bx;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                o_lat = n;
                o_res = result;
                o_ill = illegal;
                if (busy !== 1'b0) o_berr++;
                start = 1'b0;
                break;
            end
            if (busy !== 1'b1) o_berr++;
            start = 1'b0;
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        start = 1'b1;
        flush = 1'b0;
        funct3 = 3'b000;
        rs1_data = 32'd1;
        rs2_data = 32'd1;
        @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_bad++;
            $display("FAIL reset busy: got %b want 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_bad++;
            $display("FAIL reset done: got %b want 0", done); end
        n_vec++; if (illegal !== 1'b0) begin n_bad++;
            $display("FAIL reset illegal: got %b want 0", illegal); end
        n_vec++; if (result !== 32'h0) begin n_bad++;
            $display("FAIL reset result: got %h want 00000000", result); end
        start = 1'b0;
        rst   = 1'b0;
        // First edge after reset release must accept the op
        run_op(1'b0, 3'b000, 32'd7, 32'hFFFF_FFFD, lat, res, ill, berr);
        n_vec++; if (lat !== 34) begin n_bad++;
            $display("FAIL first_mul latency: got %0d want 34", lat); end
        n_vec++; if (res !== 32'hFFFF_FFEB) begin n_bad++;
            $display("FAIL first_mul result: got %h want ffffffeb", res); end
        n_vec++; if (berr !== 0) begin n_bad++;
            $display("FAIL first_mul busy: got %0d bad cycles want 0", berr); end
        n_vec++; if (ill !== 1'b0) begin n_bad++;
            $display("FAIL first_mul illegal: got %b want 0", ill); end
        @(negedge clk);
        n_vec++; if (done !== 1'b0) begin n_bad++;
            $display("FAIL done_pulse width: got %b want 0", done); end
    endtask

    task automatic test_mul;
        logic [2:0]  tf [8] = '{3'b000, 3'b011, 3'b010, 3'b001, 3'b001, 3'b000, 3'b010, 3'b001};
        logic [31:0] ta [8] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE,
                                32'h4000_0000, 32'h1234_5678, 32'd2, 32'h8000_0000};
        logic [31:0] tb [8] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd2, 32'd3,
                                32'd4, 32'h10, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [31:0] te [8] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                32'h1, 32'h2345_6780, 32'h1, 32'h4000_0000};
        for (int i = 0; i < 8; i++) begin
            run_op(1'b1, tf[i], ta[i], tb[i], lat, res, ill, berr);
            n_vec++; if (res !== te[i]) begin n_bad++;
                $display("FAIL mul[%0d] result: got %h want %h", i, res, te[i]); end
            n_vec++; if (lat !== 34) begin n_bad++;
                $display("FAIL mul[%0d] latency: got %0d want 34", i, lat); end
            n_vec++; if (ill !== 1'b0) begin n_bad++;
                $display("FAIL mul[%0d] illegal: got %b want 0", i, ill); end
            n_vec++; if (berr !== 0) begin n_bad++;
                $display("FAIL mul[%0d] busy: got %0d bad cycles want 0", i, berr); end
        end
    endtask

`ifdef MDU_DIV_EN
    task automatic test_div;
        logic [2:0]  tf [12] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b110, 3'b100,
                                 3'b101, 3'b110, 3'b100, 3'b110, 3'b101, 3'b111};
        logic [31:0] ta [12] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd7, 32'd7,
                                 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                                 32'hFFFF_FFFF};
        logic [31:0] tb [12] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFE,
                                 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                 32'h10};
        logic [31:0] te [12] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'd1,
                                 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0,
                                 32'd0, 32'hF};
        int          tl [12] = '{34, 34, 34, 34, 34, 34, 1, 1, 1, 1, 34, 34};
        for (int i = 0; i < 12; i++) begin
            run_op(1'b1, tf[i], ta[i], tb[i], lat, res, ill, berr);
            n_vec++; if (res !== te[i]) begin n_bad++;
                $display("FAIL div[%0d] result: got %h want %h", i, res, te[i]); end
            n_vec++; if (lat !== tl[i]) begin n_bad++;
                $display("FAIL div[%0d] latency: got %0d want %0d", i, lat, tl[i]); end
            n_vec++; if (ill !== 1'b0) begin n_bad++;
                $display("FAIL div[%0d] illegal: got %b want 0", i, ill); end
            n_vec++; if (berr !== 0) begin n_bad++;
                $display("FAIL div[%0d] busy: got %0d bad cycles want 0", i, berr); end
        end
    endtask
`else
    task automatic test_illegal;
        logic [2:0]  tf [3] = '{3'b100, 3'b111, 3'b101};
        logic [31:0] ta [3] = '{32'd7, 32'd100, 32'd5};
        logic [31:0] tb [3] = '{32'd2, 32'd7, 32'd0};
        for (int i = 0; i < 3; i++) begin
            run_op(1'b1, tf[i], ta[i], tb[i], lat, res, ill, berr);
            n_vec++; if (res !== 32'd0) begin n_bad++;
                $display("FAIL illegal[%0d] result: got %h want 00000000", i, res); end
            n_vec++; if (lat !== 1) begin n_bad++;
                $display("FAIL illegal[%0d] latency: got %0d want 1", i, lat); end
            n_vec++; if (ill !== 1'b1) begin n_bad++;
                $display("FAIL illegal[%0d] illegal: got %b want 1", i, ill); end
            n_vec++; if (berr !== 0) begin n_bad++;
                $display("FAIL illegal[%0d] busy: got %0d bad cycles want 0", i, berr); end
        end
        @(negedge clk);
        n_vec++; if (illegal !== 1'b0) begin n_bad++;
            $display("FAIL illegal_pulse width: got %b want 0", illegal); end
    endtask
`endif

    task automatic test_flush;
        logic saw_done;
        run_op(1'b1, 3'b000, 32'd3, 32'd5, lat, res, ill, berr);
        n_vec++; if (res !== 32'd15) begin n_bad++;
            $display("FAIL flush_pre result: got %h want 0000000f", res); end
        @(negedge clk);
        start    = 1'b1;
        funct3   = 3'b000;
        rs1_data = 32'd6;
        rs2_data = 32'd7;
        saw_done = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
            start = 1'b0;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        if (done === 1'b1) saw_done = 1'b1;
        n_vec++; if (busy !== 1'b0) begin n_bad++;
            $display("FAIL flush_calc busy at cycle 11: got %b want 0", busy); end
        n_vec++; if (saw_done !== 1'b0) begin n_bad++;
            $display("FAIL flush_calc done seen: got %b want 0", saw_done); end
        n_vec++; if (result !== 32'd15) begin n_bad++;
            $display("FAIL flush_calc result: got %h want 0000000f", result); end
        run_op(1'b1, 3'b000, 32'd6, 32'd7, lat, res, ill, berr);
        n_vec++; if (res !== 32'd42) begin n_bad++;
            $display("FAIL flush_restart result: got %h want 0000002a", res); end
        n_vec++; if (lat !== 34) begin n_bad++;
            $display("FAIL flush_restart latency: got %0d want 34", lat); end
    endtask

    task automatic test_flush_start_idle;
        logic saw_done;
        logic saw_busy;
        @(negedge clk);
        start    = 1'b1;
        flush    = 1'b1;
        funct3   = 3'b000;
        rs1_data = 32'd9;
        rs2_data = 32'd9;
        #1;
        n_vec++; if (busy !== 1'b0) begin n_bad++;
            $display("FAIL idle_flush busy: got %b want 0", busy); end
        @(negedge clk);
        start    = 1'b0;
        flush    = 1'b0;
        saw_done = 1'b0;
        saw_busy = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
            if (busy === 1'b1) saw_busy = 1'b1;
        end
        n_vec++; if (saw_done !== 1'b0) begin n_bad++;
            $display("FAIL idle_flush done seen: got %b want 0", saw_done); end
        n_vec++; if (saw_busy !== 1'b0) begin n_bad++;
            $display("FAIL idle_flush busy seen: got %b want 0", saw_busy); end
        n_vec++; if (result !== 32'd42) begin n_bad++;
            $display("FAIL idle_flush result: got %h want 0000002a", result); end
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        start    = 1'b1;
        funct3   = 3'b000;
        rs1_data = 32'd2;
        rs2_data = 32'd2;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2;
        rst = 1'b1;
        #1;
        n_vec++; if (busy !== 1'b0) begin n_bad++;
            $display("FAIL async_rst busy: got %b want 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_bad++;
            $display("FAIL async_rst done: got %b want 0", done); end
        n_vec++; if (illegal !== 1'b0) begin n_bad++;
            $display("FAIL async_rst illegal: got %b want 0", illegal); end
        n_vec++; if (result !== 32'h0) begin n_bad++;
            $display("FAIL async_rst result: got %h want 00000000", result); end
        @(negedge clk);
        rst = 1'b0;
        run_op(1'b0, 3'b011, 32'h8000_0000, 32'd6, lat, res, ill, berr);
        n_vec++; if (res !== 32'd3) begin n_bad++;
            $display("FAIL post_rst mulhu result: got %h want 00000003", res); end
        n_vec++; if (lat !== 34) begin n_bad++;
            $display("FAIL post_rst mulhu latency: got %0d want 34", lat); end
    endtask

    initial begin
        test_reset;
        test_mul;
`ifdef MDU_DIV_EN
        test_div;
`else
        test_illegal;
`endif
        test_flush;
        test_flush_start_idle;
        test_async_reset;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
